rr_hold_arbiter: RTL

RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

---
 rtl/rr_hold_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rr_hold_arbiter.sv
// Four-way round-robin arbiter with a bounded grant hold time.
// Grants, owner, busy and preempt are all registered outputs.
module rr_hold_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req3,
    input  logic       req2,
    input  logic       req1,
    input  logic       req0,
    output logic       gnt3,
    output logic       gnt2,
    output logic       gnt1,
    output logic       gnt0,
    output logic [1:0] owner,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] hcnt;
    logic [3:0] gnt_q;
    logic [1:0] owner_q;
    logic       busy_q;
    logic       preempt_q;

    logic [3:0] req;
    logic [1:0] pick;
    logic       found;
    logic [1:0] idx;
    logic       own_req;
    logic       at_max;

    assign req = {req3, req2, req1, req0};
    assign {gnt3, gnt2, gnt1, gnt0} = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

    assign own_req = req[owner_q];
    assign at_max  = (hcnt >= 8'(MAX_HOLD));

    // Search starts at ptr and walks upward, wrapping mod 4.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hcnt      <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    preempt_q <= 1'b0;
                    if (found) begin
                        state   <= GRANT;
                        gnt_q   <= 4'b0001 << pick;
                        owner_q <= pick;
                        busy_q  <= 1'b1;
                        hcnt    <= 8'd1;
                    end
                end
                GRANT: begin
                    if (own_req && !at_max) begin
                        hcnt <= hcnt + 8'd1;
                    end else begin
                        // A release on the limit cycle is a normal release.
                        state     <= TURN;
                        preempt_q <= own_req;
                        ptr       <= owner_q + 2'd1;
                        gnt_q     <= '0;
                        owner_q   <= '0;
                        busy_q    <= 1'b0;
                        hcnt      <= '0;
                    end
                end
                TURN: begin
                    state     <= IDLE;
                    preempt_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    gnt_q     <= '0;
                    owner_q   <= '0;
                    busy_q    <= 1'b0;
                    preempt_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
